sap1_cs: RTL and testbench



---
 rtl/sap1_pkg.sv | 37 +++
 rtl/sap1_ring.sv | 35 +++
 rtl/sap1_cs.sv | 112 +++++++++++
 tb/tb_sap1_cs.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot ring states and control-word bit positions.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam int CW_W  = 12;
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    typedef logic [CW_W-1:0] ctrl_word_t;

    function automatic ctrl_word_t cw_bit(input int idx);
        return ctrl_word_t'(1) << idx;
    endfunction

endpackage

// File: rtl/sap1_ring.sv
// Six-state one-hot ring counter advancing on the falling clock edge, async clear to T1.
module sap1_ring
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    input  logic       restart,
    output logic [5:0] t
);

    logic [5:0] t_q;
    logic [5:0] t_d;

    // Only rotate, hold or reload T1, so the ring can never leave one-hot.
    always_comb begin
        t_d = {t_q[4:0], t_q[5]};
        if (hold) begin
            t_d = t_q;
        end else if (restart) begin
            t_d = T1;
        end
    end

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            t_q <= T1;
        end else begin
            t_q <= t_d;
        end
    end

    assign t = t_q;

endmodule

// File: rtl/sap1_cs.sv
// SAP-1 controller-sequencer: ring counter, instruction decoder and halt flag.
// Build option SAP1_CS_VARIABLE_RING_EN ends each instruction after its last active state.
module sap1_cs
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] opcode,
    output logic [5:0] t,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt
);

    // Load/enable contract: each strobe is a level held for one whole T-state; the
    // register blocks act on the rising edge in the middle of that state.
    logic       halted_q;
    logic       halted_d;
    logic       restart;
    ctrl_word_t cw;

    sap1_ring u_ring (
        .clk     (clk),
        .clr     (clr),
        .hold    (halted_d),
        .restart (restart),
        .t       (t)
    );

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    always_comb begin
        halted_d = halted_q | ((t == T4) && (opcode == OP_HLT));
        restart  = 1'b0;
`ifdef SAP1_CS_VARIABLE_RING_EN
        case (opcode)
            OP_LDA:         restart = (t == T5);
            OP_ADD, OP_SUB: restart = (t == T6);
            OP_OUT:         restart = (t == T4);
            OP_HLT:         restart = 1'b0;
            default:        restart = (t == T3);
        endcase
`endif
    end

    always_comb begin
        cw  = '0;
        hlt = halted_q;
        if (!halted_q) begin
            case (t)
                T1: cw = cw_bit(CW_EP) | cw_bit(CW_LM);
                T2: cw = cw_bit(CW_CP);
                T3: cw = cw_bit(CW_CE) | cw_bit(CW_LI);
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD: cw = cw_bit(CW_EI) | cw_bit(CW_LM);
                        OP_SUB:         cw = cw_bit(CW_EI) | cw_bit(CW_LM) | cw_bit(CW_SU);
                        OP_OUT:         cw = cw_bit(CW_EA) | cw_bit(CW_LO);
                        OP_HLT:         hlt = 1'b1;
                        default:        cw = '0;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:  cw = cw_bit(CW_CE) | cw_bit(CW_LA);
                        OP_ADD:  cw = cw_bit(CW_CE) | cw_bit(CW_LB);
                        OP_SUB:  cw = cw_bit(CW_CE) | cw_bit(CW_LB) | cw_bit(CW_SU);
                        default: cw = '0;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD:  cw = cw_bit(CW_LA) | cw_bit(CW_EU);
                        OP_SUB:  cw = cw_bit(CW_LA) | cw_bit(CW_EU) | cw_bit(CW_SU);
                        default: cw = '0;
                    endcase
                end
                default: cw = '0;
            endcase
        end
    end

    assign cp = cw[CW_CP];
    assign ep = cw[CW_EP];
    assign lm = cw[CW_LM];
    assign ce = cw[CW_CE];
    assign li = cw[CW_LI];
    assign ei = cw[CW_EI];
    assign la = cw[CW_LA];
    assign ea = cw[CW_EA];
    assign su = cw[CW_SU];
    assign eu = cw[CW_EU];
    assign lb = cw[CW_LB];
    assign lo = cw[CW_LO];

endmodule

// File: tb/tb_sap1_cs.sv
// Directed bench for sap1_cs; honours SAP1_CS_VARIABLE_RING_EN when defined.
module tb_sap1_cs;

    // Expected control vector layout: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo,hlt}
    localparam logic [12:0] K_CP  = 13'b1_0000_0000_0000;
    localparam logic [12:0] K_EP  = 13'b0_1000_0000_0000;
    localparam logic [12:0] K_LM  = 13'b0_0100_0000_0000;
    localparam logic [12:0] K_CE  = 13'b0_0010_0000_0000;
    localparam logic [12:0] K_LI  = 13'b0_0001_0000_0000;
    localparam logic [12:0] K_EI  = 13'b0_0000_1000_0000;
    localparam logic [12:0] K_LA  = 13'b0_0000_0100_0000;
    localparam logic [12:0] K_EA  = 13'b0_0000_0010_0000;
    localparam logic [12:0] K_SU  = 13'b0_0000_0001_0000;
    localparam logic [12:0] K_EU  = 13'b0_0000_0000_1000;
    localparam logic [12:0] K_LB  = 13'b0_0000_0000_0100;
    localparam logic [12:0] K_LO  = 13'b0_0000_0000_0010;
    localparam logic [12:0] K_HLT = 13'b0_0000_0000_0001;
    localparam logic [12:0] K_NONE = 13'b0;

`ifdef SAP1_CS_VARIABLE_RING_EN
    localparam int LEN_LDA = 5;
    localparam int LEN_OUT = 4;
    localparam int LEN_NOP = 3;
`else
    localparam int LEN_LDA = 6;
    localparam int LEN_OUT = 6;
    localparam int LEN_NOP = 6;
`endif

    logic       clk;
    logic       clr;
    logic [3:0] opcode;
    logic [5:0] t;
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
    logic [12:0] ctrl_obs;

    int checks;
    int failures;

    sap1_cs dut (
        .clk    (clk),
        .clr    (clr),
        .opcode (opcode),
        .t      (t),
        .cp     (cp),
        .ep     (ep),
        .lm     (lm),
        .ce     (ce),
        .li     (li),
        .ei     (ei),
        .la     (la),
        .ea     (ea),
        .su     (su),
        .eu     (eu),
        .lb     (lb),
        .lo     (lo),
        .hlt    (hlt)
    );

    assign ctrl_obs = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt};

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Step past the next falling edge (the ring's active edge) and settle.
    task automatic advance();
        @(negedge clk);
        #1;
    endtask

    // Walk one instruction of n states, checking t and the control word in each.
    task automatic run_instr(input string name, input logic [3:0] op, input int n,
                             input logic [12:0] e4, input logic [12:0] e5,
                             input logic [12:0] e6);
        logic [12:0] exp_c;
        logic [5:0]  exp_t;
        opcode = op;
        for (int i = 0; i < n; i++) begin
            exp_t = 6'b000001 << i;
            case (i)
                0:       exp_c = K_EP | K_LM;
                1:       exp_c = K_CP;
                2:       exp_c = K_CE | K_LI;
                3:       exp_c = e4;
                4:       exp_c = e5;
                default: exp_c = e6;
            endcase
            check($sformatf("%s_t%0d_state", name, i + 1), 32'(t), 32'(exp_t));
            check($sformatf("%s_t%0d_ctrl", name, i + 1), 32'(ctrl_obs), 32'(exp_c));
            advance();
        end
        check($sformatf("%s_wrap", name), 32'(t), 32'(6'b000001));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr      = 1'b1;
        opcode   = 4'h0;
        #2;
        check("reset_state", 32'(t), 32'(6'b000001));
        check("reset_ctrl", 32'(ctrl_obs), 32'(K_EP | K_LM));
        #10;
        clr = 1'b0;
        check("post_reset_state", 32'(t), 32'(6'b000001));

        run_instr("lda", 4'b0000, LEN_LDA, K_EI | K_LM, K_CE | K_LA, K_NONE);
        run_instr("sub", 4'b0010, 6, K_EI | K_LM | K_SU, K_CE | K_LB | K_SU,
                  K_LA | K_EU | K_SU);
        run_instr("add", 4'b0001, 6, K_EI | K_LM, K_CE | K_LB, K_LA | K_EU);
        run_instr("out", 4'b1110, LEN_OUT, K_EA | K_LO, K_NONE, K_NONE);
        run_instr("nop", 4'b0101, LEN_NOP, K_NONE, K_NONE, K_NONE);

        // Asynchronous clear in the middle of ADD T5
        opcode = 4'b0001;
        repeat (4) advance();
        check("addclr_t5_state", 32'(t), 32'(6'b010000));
        check("addclr_t5_ctrl", 32'(ctrl_obs), 32'(K_CE | K_LB));
        #2;
        clr = 1'b1;
        #1;
        check("addclr_state", 32'(t), 32'(6'b000001));
        check("addclr_ctrl", 32'(ctrl_obs), 32'(K_EP | K_LM));
        clr = 1'b0;
        #1;
        run_instr("add_after_clr", 4'b0001, 6, K_EI | K_LM, K_CE | K_LB, K_LA | K_EU);

        // HLT: freeze in T4 with only hlt asserted, independent of later opcodes
        opcode = 4'b1111;
        repeat (3) advance();
        check("hlt_t4_state", 32'(t), 32'(6'b001000));
        check("hlt_t4_ctrl", 32'(ctrl_obs), 32'(K_HLT));
        advance();
        opcode = 4'b0000;
        repeat (9) advance();
        check("halted_state", 32'(t), 32'(6'b001000));
        check("halted_ctrl", 32'(ctrl_obs), 32'(K_HLT));
        #2;
        clr = 1'b1;
        #1;
        check("hltclr_state", 32'(t), 32'(6'b000001));
        check("hltclr_ctrl", 32'(ctrl_obs), 32'(K_EP | K_LM));
        clr = 1'b0;
        #1;
        run_instr("lda_after_hlt", 4'b0000, LEN_LDA, K_EI | K_LM, K_CE | K_LA, K_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
